// File: rtl/vga_timing_rx.sv
// VGA sync receiver: measures line/frame timing, locks onto a stable raster and reports active-area coordinates.
// Define VGA_TIMING_RX_STATS_EN to enable the saturating lock-loss counter on err_count.
module vga_timing_rx #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_START     = 144,
    parameter int unsigned V_START     = 35,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter bit          SYNC_POL    = 1'b0
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       pixel_en,
    input  logic       hsync_n,
    input  logic       vsync_n,
    output logic       locked,
    output logic       active,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       frame_start,
    output logic       lock_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

    localparam logic [9:0]  CNT_MAX = '1;
    localparam logic [9:0]  H_TOT   = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
    localparam logic [10:0] H_LO    = 11'(H_START);
    localparam logic [10:0] H_HI    = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO    = 11'(V_START);
    localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);
    localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);
    localparam logic        IDLE    = ~SYNC_POL;

    logic [1:0] hs_sync, vs_sync;
    logic       hs_prev, vs_prev;
    logic       h_edge, v_edge;
    logic [9:0] h_cnt, v_cnt, line_meas;
    logic       line_bad, cnt_sat, in_area;
    state_t     state, state_nxt;
    logic [2:0] good_cnt, good_nxt;
    logic       frame_bad, bad_nxt, err_nxt;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            hs_sync <= {2{IDLE}};
            vs_sync <= {2{IDLE}};
            hs_prev <= IDLE;
            vs_prev <= IDLE;
        end else begin
            hs_sync <= {hs_sync[0], hsync_n};
            vs_sync <= {vs_sync[0], vsync_n};
            if (pixel_en) begin
                hs_prev <= hs_sync[1];
                vs_prev <= vs_sync[1];
            end
        end
    end

    assign h_edge    = pixel_en && (hs_sync[1] == SYNC_POL) && (hs_prev == IDLE);
    assign v_edge    = pixel_en && (vs_sync[1] == SYNC_POL) && (vs_prev == IDLE);
    assign line_meas = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
    assign line_bad  = h_edge && (line_meas != H_TOT);
    assign cnt_sat   = (h_cnt == CNT_MAX) || (v_cnt == CNT_MAX);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else if (pixel_en) begin
            if (h_edge) begin
                h_cnt    <= '0;
                line_len <= line_meas;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + 10'd1;
            end
            // vsync restart wins over the line increment when both edges coincide
            if (v_edge) begin
                v_cnt       <= '0;
                frame_lines <= v_cnt;
            end else if (h_edge && (v_cnt != CNT_MAX)) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = frame_bad;
        err_nxt   = 1'b0;
        case (state)
            SEEK: begin
                if (v_edge) begin
                    state_nxt = MEASURE;
                    good_nxt  = '0;
                    bad_nxt   = 1'b0;
                end
            end
            MEASURE: begin
                if (cnt_sat) begin
                    state_nxt = SEEK;
                end else begin
                    if (line_bad)
                        bad_nxt = 1'b1;
                    if (v_edge) begin
                        if ((v_cnt == V_TOT) && !bad_nxt) begin
                            good_nxt = good_cnt + 3'd1;
                            if (good_nxt == LOCK_N)
                                state_nxt = LOCKED;
                        end else begin
                            good_nxt = '0;
                        end
                        bad_nxt = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if (line_bad)
                    bad_nxt = 1'b1;
                if (cnt_sat || line_bad || (v_edge && (v_cnt != V_TOT))) begin
                    state_nxt = SEEK;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    assign locked  = (state == LOCKED);
    assign in_area = locked
                     && ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI)
                     && ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state       <= SEEK;
            good_cnt    <= '0;
            frame_bad   <= 1'b0;
            lock_err    <= 1'b0;
            frame_start <= 1'b0;
            active      <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_nxt;
            frame_bad   <= bad_nxt;
            lock_err    <= err_nxt;
            frame_start <= v_edge && locked;
            active      <= in_area;
            x_pos       <= in_area ? h_cnt - H_LO[9:0] : '0;
            y_pos       <= in_area ? v_cnt - V_LO[9:0] : '0;
        end
    end

`ifdef VGA_TIMING_RX_STATS_EN
    always_ff @(posedge clk_50) begin
        if (reset)
            err_count <= '0;
        else if (lock_err && (err_count != '1))
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx on a reduced raster; DUT 0 uses low-active sync, DUT 1 an inverted stream with SYNC_POL=1.
module tb_vga_timing_rx;

    localparam int HT   = 40;
    localparam int VT   = 20;
    localparam int HS_W = 6;
    localparam int VS_OFF = 3;   // vsync edge lands mid-line so each frame counts VT hsync edges
    localparam int HA   = 24;
    localparam int VA   = 12;
`ifdef VGA_TIMING_RX_STATS_EN
    localparam int ERR_STEP = 1;
`else
    localparam int ERR_STEP = 0;
`endif

    logic clk_50 = 1'b0;
    logic reset = 1'b0;
    logic pixel_en = 1'b0;
    logic hs_a = 1'b0;
    logic vs_a = 1'b0;

    logic       locked [2];
    logic       active [2];
    logic [9:0] x_pos [2];
    logic [9:0] y_pos [2];
    logic [9:0] line_len [2];
    logic [9:0] frame_lines [2];
    logic       frame_start [2];
    logic       lock_err [2];
    logic [7:0] err_count [2];

    int checks = 0;
    int errors = 0;

    always #10 clk_50 = ~clk_50;

    vga_timing_rx #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(10), .V_START(4),
                    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2), .SYNC_POL(1'b0)) u_dut0 (
        .clk_50(clk_50), .reset(reset), .pixel_en(pixel_en),
        .hsync_n(~hs_a), .vsync_n(~vs_a),
        .locked(locked[0]), .active(active[0]), .x_pos(x_pos[0]), .y_pos(y_pos[0]),
        .line_len(line_len[0]), .frame_lines(frame_lines[0]), .frame_start(frame_start[0]),
        .lock_err(lock_err[0]), .err_count(err_count[0])
    );

    vga_timing_rx #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(10), .V_START(4),
                    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2), .SYNC_POL(1'b1)) u_dut1 (
        .clk_50(clk_50), .reset(reset), .pixel_en(pixel_en),
        .hsync_n(hs_a), .vsync_n(vs_a),
        .locked(locked[1]), .active(active[1]), .x_pos(x_pos[1]), .y_pos(y_pos[1]),
        .line_len(line_len[1]), .frame_lines(frame_lines[1]), .frame_start(frame_start[1]),
        .lock_err(lock_err[1]), .err_count(err_count[1])
    );

    int         act_cyc [2];
    int         err_pulses [2];
    int         fs_pulses [2];
    int         xy_bad [2];
    bit         seen [2];
    logic [9:0] first_x [2], first_y [2], last_x [2], last_y [2];

    always begin
        @(posedge clk_50);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (active[i]) begin
                if (!seen[i]) begin
                    first_x[i] = x_pos[i];
                    first_y[i] = y_pos[i];
                    seen[i] = 1'b1;
                end
                last_x[i] = x_pos[i];
                last_y[i] = y_pos[i];
                act_cyc[i]++;
            end else if (x_pos[i] != 10'd0 || y_pos[i] != 10'd0) begin
                xy_bad[i]++;
            end
            if (lock_err[i]) err_pulses[i]++;
            if (frame_start[i]) fs_pulses[i]++;
        end
    end

    int line = 0;
    int tick = 0;
    int cur_len = HT;
    bit hold = 1'b0;

    task automatic clr_mon();
        for (int i = 0; i < 2; i++) begin
            act_cyc[i] = 0; err_pulses[i] = 0; fs_pulses[i] = 0; xy_bad[i] = 0; seen[i] = 1'b0;
        end
    endtask

    task automatic do_tick();
        @(negedge clk_50);
        if (hold) begin
            hs_a = 1'b0;
            vs_a = 1'b0;
        end else begin
            hs_a = (tick < HS_W);
            vs_a = (line == 0 && tick >= VS_OFF) || line == 1 || (line == 2 && tick < VS_OFF);
        end
        pixel_en = 1'b1;
        @(negedge clk_50);
        pixel_en = 1'b0;
        if (!hold) begin
            tick++;
            if (tick >= cur_len) begin
                tick = 0;
                cur_len = HT;
                line = (line + 1) % VT;
            end
        end
    endtask

    task automatic send_ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    task automatic send_until(input int target);
        for (int k = 0; k < HT * VT + HT; k++) begin
            do_tick();
            if (line == target && tick == 0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_50);
        @(negedge clk_50);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({locked[i], active[i], frame_start[i], lock_err[i]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_flags dut%0d got %b want 0000", i,
                         {locked[i], active[i], frame_start[i], lock_err[i]});
            end
            checks++;
            if ({x_pos[i], y_pos[i], line_len[i], frame_lines[i], err_count[i]} !== 48'd0) begin
                errors++;
                $display("FAIL reset_values dut%0d x=%0d y=%0d ll=%0d fl=%0d ec=%0d want all 0", i,
                         x_pos[i], y_pos[i], line_len[i], frame_lines[i], err_count[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        line = 0; tick = 0;
        clr_mon();
        send_ticks(2 * VT * HT);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (locked[i] !== 1'b0) begin
                errors++;
                $display("FAIL lock_early dut%0d locked got %b want 0 after 2 vsync edges", i, locked[i]);
            end
        end
        send_ticks(HT);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (locked[i] !== 1'b1) begin
                errors++;
                $display("FAIL lock_rise dut%0d locked got %b want 1 after 3rd vsync edge", i, locked[i]);
            end
            checks++;
            if (line_len[i] !== 10'(HT) || frame_lines[i] !== 10'(VT)) begin
                errors++;
                $display("FAIL measure dut%0d line_len=%0d frame_lines=%0d want %0d/%0d", i,
                         line_len[i], frame_lines[i], HT, VT);
            end
            checks++;
            if (err_pulses[i] != 0) begin
                errors++;
                $display("FAIL lock_no_err dut%0d lock_err pulses got %0d want 0", i, err_pulses[i]);
            end
        end
    endtask

    task automatic test_active();
        clr_mon();
        send_until(0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_cyc[i] != 2 * HA * VA) begin
                errors++;
                $display("FAIL active_count dut%0d cycles got %0d want %0d", i, act_cyc[i], 2 * HA * VA);
            end
            checks++;
            if (first_x[i] !== 10'd0 || first_y[i] !== 10'd0) begin
                errors++;
                $display("FAIL first_pixel dut%0d got (%0d,%0d) want (0,0)", i, first_x[i], first_y[i]);
            end
            checks++;
            if (last_x[i] !== 10'(HA - 1) || last_y[i] !== 10'(VA - 1)) begin
                errors++;
                $display("FAIL last_pixel dut%0d got (%0d,%0d) want (%0d,%0d)", i,
                         last_x[i], last_y[i], HA - 1, VA - 1);
            end
            checks++;
            if (xy_bad[i] != 0) begin
                errors++;
                $display("FAIL xy_idle dut%0d nonzero coords while inactive got %0d want 0", i, xy_bad[i]);
            end
        end
        send_ticks(HT);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (fs_pulses[i] != 1 || locked[i] !== 1'b1) begin
                errors++;
                $display("FAIL frame_start dut%0d pulses=%0d locked=%b want 1/1", i, fs_pulses[i], locked[i]);
            end
        end
    endtask

    task automatic test_short_line();
        clr_mon();
        send_until(6);
        cur_len = HT - 1;
        send_until(8);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (err_pulses[i] != 1 || locked[i] !== 1'b0) begin
                errors++;
                $display("FAIL short_line dut%0d lock_err pulses=%0d locked=%b want 1/0", i,
                         err_pulses[i], locked[i]);
            end
            checks++;
            if (err_count[i] !== 8'(ERR_STEP)) begin
                errors++;
                $display("FAIL err_count_1 dut%0d got %0d want %0d", i, err_count[i], ERR_STEP);
            end
        end
        send_until(0);
        send_ticks(2 * VT * HT);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (locked[i] !== 1'b0) begin
                errors++;
                $display("FAIL relock_early dut%0d locked got %b want 0", i, locked[i]);
            end
        end
        send_ticks(HT);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (locked[i] !== 1'b1 || err_pulses[i] != 1) begin
                errors++;
                $display("FAIL relock dut%0d locked=%b pulses=%0d want 1/1", i, locked[i], err_pulses[i]);
            end
        end
    endtask

    task automatic test_hsync_hold();
        clr_mon();
        send_until(4);
        hold = 1'b1;
        send_ticks(1100);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (err_pulses[i] != 1 || locked[i] !== 1'b0 || active[i] !== 1'b0) begin
                errors++;
                $display("FAIL hsync_hold dut%0d pulses=%0d locked=%b active=%b want 1/0/0", i,
                         err_pulses[i], locked[i], active[i]);
            end
            checks++;
            if (err_count[i] !== 8'(2 * ERR_STEP)) begin
                errors++;
                $display("FAIL err_count_2 dut%0d got %0d want %0d", i, err_count[i], 2 * ERR_STEP);
            end
        end
        hold = 1'b0;
        line = 0;
        tick = 0;
    endtask

    task automatic test_reset_mid_frame();
        send_ticks(2 * VT * HT + HT);
        send_until(8);
        send_ticks(20);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (locked[i] !== 1'b1 || active[i] !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset dut%0d locked=%b active=%b want 1/1", i, locked[i], active[i]);
            end
        end
        @(negedge clk_50);
        reset = 1'b1;
        @(posedge clk_50);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (locked[i] !== 1'b0 || x_pos[i] !== 10'd0 || line_len[i] !== 10'd0 || active[i] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset dut%0d locked=%b x=%0d line_len=%0d active=%b want 0", i,
                         locked[i], x_pos[i], line_len[i], active[i]);
            end
            checks++;
            if (err_count[i] !== 8'd0 || frame_lines[i] !== 10'd0) begin
                errors++;
                $display("FAIL mid_reset_stats dut%0d ec=%0d fl=%0d want 0/0", i, err_count[i], frame_lines[i]);
            end
        end
        @(negedge clk_50);
        reset = 1'b0;
        clr_mon();
        send_until(0);
        send_ticks(2 * VT * HT);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (locked[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_relock_early dut%0d locked got %b want 0", i, locked[i]);
            end
        end
        send_ticks(HT);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (locked[i] !== 1'b1 || err_pulses[i] != 0) begin
                errors++;
                $display("FAIL reset_relock dut%0d locked=%b pulses=%0d want 1/0", i, locked[i], err_pulses[i]);
            end
        end
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_lock();
        test_active();
        test_short_line();
        test_hsync_hold();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
